// File: rtl/eq_audio_pkg.sv
// Shared types and constants for the 3-band equalizer audio path.
// Sample width and I2S slot geometry are common to the EQ core and its output stage.
package eq_audio_pkg;

  localparam int SAMPLE_W     = 24;
  localparam int I2S_SLOT_W   = 32;
  localparam int I2S_BCLK_DIV = 4;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// Stereo sample handshake from the EQ core into the I2S transmitter.
interface i2s_tx_serializer_if #(
  parameter int DATA_W = eq_audio_pkg::SAMPLE_W
);

  logic signed [DATA_W-1:0] s_data_l;
  logic signed [DATA_W-1:0] s_data_r;
  logic                     s_valid;
  logic                     s_ready;

  modport master (output s_data_l, output s_data_r, output s_valid, input s_ready);
  modport slave  (input s_data_l, input s_data_r, input s_valid, output s_ready);

endinterface

// File: rtl/i2s_clkgen.sv
// I2S bit/frame timing: BCLK divider and frame position counters, registered BCLK/LRCLK,
// plus the bit (position advance) and frame (load) strobes for the shifter.
module i2s_clkgen import eq_audio_pkg::*; #(
  parameter int SLOT_W   = I2S_SLOT_W,
  parameter int BCLK_DIV = I2S_BCLK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  output logic bclk_o,
  output logic lrclk_o,
  output logic bit_tick_o,
  output logic frame_tick_o
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int P_W   = $clog2(2 * SLOT_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [P_W-1:0]   P_LAST   = P_W'(2 * SLOT_W - 1);
  localparam logic [P_W-1:0]   P_SLOT   = P_W'(SLOT_W);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [P_W-1:0]   p_q, p_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  logic             bit_tick, frame_tick;

  always_comb begin
    bit_tick   = en_i && (div_cnt_q == DIV_LAST);
    frame_tick = en_i && (div_cnt_q == '0) && (p_q == '0);
    div_cnt_d  = '0;
    p_d        = '0;
    bclk_d     = 1'b0;
    lrclk_d    = 1'b0;
    // Outputs follow the counter state one clk later, so they all switch together.
    if (en_i) begin
      div_cnt_d = bit_tick ? '0 : div_cnt_q + 1'b1;
      p_d       = p_q;
      if (bit_tick) begin
        p_d = (p_q == P_LAST) ? '0 : p_q + 1'b1;
      end
      bclk_d  = (div_cnt_q >= DIV_HALF);
      lrclk_d = (p_q >= P_SLOT);
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      div_cnt_q <= '0;
      p_q       <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      p_q       <= p_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
    end
  end

  assign bclk_o       = bclk_q;
  assign lrclk_o      = lrclk_q;
  assign bit_tick_o   = bit_tick;
  assign frame_tick_o = frame_tick;

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: one-entry stereo holding buffer, frame shifter and underrun/frame pulses.
// Reset input reset_n is asynchronous and active-high despite its name.
module i2s_tx_serializer import eq_audio_pkg::*; #(
  parameter int DATA_W   = SAMPLE_W,
  parameter int SLOT_W   = I2S_SLOT_W,
  parameter int BCLK_DIV = I2S_BCLK_DIV
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  i2s_tx_serializer_if.slave s_if,
  output logic              i2s_bclk,
  output logic              i2s_lrclk,
  output logic              i2s_sdata,
  output logic              frame_start,
  output logic              underrun
);

  localparam int FRAME_W = 2 * SLOT_W;

  logic [DATA_W-1:0]  buf_l_q, buf_l_d;
  logic [DATA_W-1:0]  buf_r_q, buf_r_d;
  logic               full_q, full_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               sdata_q, sdata_d;
  logic               bit_tick, frame_tick, accept;

  // One leading zero (I2S one-bit delay), sample MSB first, zero pad to the slot end.
  function automatic logic [SLOT_W-1:0] to_slot(input logic [DATA_W-1:0] s);
    logic [SLOT_W-1:0] slot;
    slot = '0;
    slot[SLOT_W-2 -: DATA_W] = s;
    return slot;
  endfunction

  i2s_clkgen #(
    .SLOT_W   (SLOT_W),
    .BCLK_DIV (BCLK_DIV)
  ) u_clkgen (
    .clk          (clk),
    .reset_n      (reset_n),
    .en_i         (en),
    .bclk_o       (i2s_bclk),
    .lrclk_o      (i2s_lrclk),
    .bit_tick_o   (bit_tick),
    .frame_tick_o (frame_tick)
  );

  always_comb begin
    buf_l_d = buf_l_q;
    buf_r_d = buf_r_q;
    full_d  = full_q;
    shift_d = shift_q;
    accept  = s_if.s_valid && !full_q;
    sdata_d = en && shift_q[FRAME_W-1];

    // Load needs a full buffer and accept an empty one, so they never contend.
    if (frame_tick && full_q) begin
      full_d = 1'b0;
    end
    if (accept) begin
      buf_l_d = s_if.s_data_l;
      buf_r_d = s_if.s_data_r;
      full_d  = 1'b1;
    end

    if (!en) begin
      shift_d = '0;
    end else if (frame_tick) begin
      shift_d = full_q ? {to_slot(buf_l_q), to_slot(buf_r_q)} : '0;
    end else if (bit_tick) begin
      shift_d = {shift_q[FRAME_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      buf_l_q <= '0;
      buf_r_q <= '0;
      full_q  <= 1'b0;
      shift_q <= '0;
      sdata_q <= 1'b0;
    end else begin
      buf_l_q <= buf_l_d;
      buf_r_q <= buf_r_d;
      full_q  <= full_d;
      shift_q <= shift_d;
      sdata_q <= sdata_d;
    end
  end

  assign s_if.s_ready = !full_q;
  assign i2s_sdata    = sdata_q;
  assign frame_start  = frame_tick && !reset_n;
  assign underrun     = frame_start && !full_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: reset, preload frame, underrun, streaming,
// mid-frame reset and en drop, with frames captured on BCLK rising edges.
module tb_i2s_tx_serializer;
  import eq_audio_pkg::*;

  localparam int DATA_W   = 24;
  localparam int SLOT_W   = 32;
  localparam int BCLK_DIV = 4;
  localparam logic [63:0] LR_PATTERN = 64'h00000000_FFFFFFFF;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic en = 1'b0;
  logic i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_fs_cyc = 0;

  i2s_tx_serializer_if #(.DATA_W(DATA_W)) s_if ();

  i2s_tx_serializer #(
    .DATA_W   (DATA_W),
    .SLOT_W   (SLOT_W),
    .BCLK_DIV (BCLK_DIV)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .s_if        (s_if),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sdata   (i2s_sdata),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: bench did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Wire image of one frame: 0, L (MSB first), 7 zeros, 0, R, 7 zeros.
  function automatic logic [63:0] exp_frame(input sample_t l, input sample_t r);
    return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
  endfunction

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Collects 64 bits on BCLK rising edges; rdy1 is s_ready one clk after the call.
  task automatic capture(output logic [63:0] bits, output logic [63:0] lr,
                         output logic rdy1, output bit ok);
    logic prev;
    int n;
    prev = i2s_bclk;
    n    = 0;
    bits = '0;
    lr   = '0;
    rdy1 = 1'b0;
    for (int i = 0; i < 300 && n < 64; i++) begin
      @(negedge clk);
      if (i == 0) rdy1 = s_if.s_ready;
      if (i2s_bclk === 1'b1 && prev === 1'b0) begin
        bits[63-n] = i2s_sdata;
        lr[63-n]   = i2s_lrclk;
        n++;
      end
      prev = i2s_bclk;
    end
    ok = (n == 64);
  endtask

  task automatic load_pair(input sample_t l, input sample_t r);
    @(negedge clk);
    s_if.s_data_l = l;
    s_if.s_data_r = r;
    s_if.s_valid  = 1'b1;
    @(negedge clk);
    s_if.s_valid  = 1'b0;
  endtask

  task automatic test_reset;
    int bad;
    reset_n = 1'b1;
    en = 1'b0;
    s_if.s_valid = 1'b0;
    s_if.s_data_l = '0;
    s_if.s_data_r = '0;
    repeat (3) @(negedge clk);
    vectors++; if (i2s_bclk !== 1'b0) begin miscompares++; $display("FAIL reset_bclk: got %b want 0", i2s_bclk); end
    vectors++; if (i2s_lrclk !== 1'b0) begin miscompares++; $display("FAIL reset_lrclk: got %b want 0", i2s_lrclk); end
    vectors++; if (i2s_sdata !== 1'b0) begin miscompares++; $display("FAIL reset_sdata: got %b want 0", i2s_sdata); end
    vectors++; if (s_if.s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", s_if.s_ready); end
    vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    reset_n = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i2s_bclk !== 1'b0 || frame_start !== 1'b0) bad++;
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL idle_bclk: got %0d active cycles want 0", bad); end
    $display("reset: outputs idle for 100 clk with en=0");
  endtask

  task automatic test_preload;
    logic [63:0] bits, lr, want;
    logic rdy1;
    bit ok;
    load_pair(24'hA50F3C, 24'h800001);
    vectors++; if (s_if.s_ready !== 1'b0) begin miscompares++; $display("FAIL preload_ready: got %b want 0", s_if.s_ready); end
    en = 1'b1;
    #1;
    last_fs_cyc = cyc;
    vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL preload_fs: got %b want 1", frame_start); end
    vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL preload_underrun: got %b want 0", underrun); end
    capture(bits, lr, rdy1, ok);
    want = exp_frame(24'hA50F3C, 24'h800001);
    vectors++; if (!ok) begin miscompares++; $display("FAIL preload_capture: got timeout want 64 bclk edges"); end
    vectors++; if (bits !== want) begin miscompares++; $display("FAIL preload_bits: got %h want %h", bits, want); end
    vectors++; if (lr !== LR_PATTERN) begin miscompares++; $display("FAIL preload_lrclk: got %h want %h", lr, LR_PATTERN); end
    vectors++; if (rdy1 !== 1'b1) begin miscompares++; $display("FAIL preload_ready_after: got %b want 1", rdy1); end
    $display("preload frame: bits %h", bits);
  endtask

  task automatic test_underrun;
    logic [63:0] bits, lr;
    logic rdy1;
    bit ok;
    for (int f = 0; f < 2; f++) begin
      wait_fs(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL underrun_wait%0d: got timeout want frame_start", f); end
      vectors++; if (underrun !== 1'b1) begin miscompares++; $display("FAIL underrun_flag%0d: got %b want 1", f, underrun); end
      vectors++; if (cyc - last_fs_cyc != 256) begin miscompares++; $display("FAIL underrun_period%0d: got %0d want 256", f, cyc - last_fs_cyc); end
      last_fs_cyc = cyc;
      capture(bits, lr, rdy1, ok);
      vectors++; if (bits !== 64'h0 || !ok) begin miscompares++; $display("FAIL underrun_bits%0d: got %h want 0", f, bits); end
      $display("underrun frame %0d: bits %h", f, bits);
    end
  endtask

  task automatic test_stream;
    sample_t exp_l [0:7];
    sample_t exp_r [0:7];
    int n_acc;
    bit stop;
    sample_t cur_l, cur_r;
    n_acc = 0;
    stop  = 1'b0;
    cur_l = 24'h123456;
    cur_r = 24'hFEDCBA;
    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    s_if.s_data_l = cur_l;
    s_if.s_data_r = cur_r;
    s_if.s_valid  = 1'b1;
    en = 1'b1;
    #1;
    vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL stream_fs0: got %b want 1", frame_start); end
    vectors++; if (underrun !== 1'b1) begin miscompares++; $display("FAIL stream_underrun0: got %b want 1", underrun); end
    fork
      begin : driver
        bit acc;
        while (!stop) begin
          acc = s_if.s_ready;
          if (acc && n_acc < 8) begin
            exp_l[n_acc] = cur_l;
            exp_r[n_acc] = cur_r;
            n_acc++;
          end
          @(negedge clk);
          if (acc) begin
            cur_l = cur_l + 24'h10F0E1;
            cur_r = cur_r - 24'h0A0B0C;
            s_if.s_data_l = cur_l;
            s_if.s_data_r = cur_r;
          end
        end
      end
      begin : monitor
        logic [63:0] bits, lr, want;
        logic rdy1;
        bit ok;
        for (int f = 0; f < 4; f++) begin
          if (f > 0) begin
            wait_fs(ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL stream_wait%0d: got timeout want frame_start", f); end
            vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL stream_underrun%0d: got %b want 0", f, underrun); end
          end
          capture(bits, lr, rdy1, ok);
          want = (f == 0) ? 64'h0 : exp_frame(exp_l[f-1], exp_r[f-1]);
          vectors++; if (bits !== want || !ok) begin miscompares++; $display("FAIL stream_bits%0d: got %h want %h", f, bits, want); end
          vectors++; if (lr !== LR_PATTERN) begin miscompares++; $display("FAIL stream_lrclk%0d: got %h want %h", f, lr, LR_PATTERN); end
          if (f > 0) begin
            vectors++; if (rdy1 !== 1'b1) begin miscompares++; $display("FAIL stream_ready%0d: got %b want 1", f, rdy1); end
          end
          $display("stream frame %0d: bits %h", f, bits);
        end
        stop = 1'b1;
      end
    join
    s_if.s_valid = 1'b0;
    vectors++; if (n_acc != 4) begin miscompares++; $display("FAIL stream_accepts: got %0d want 4", n_acc); end
  endtask

  task automatic test_reset_midframe;
    logic [63:0] bits, lr;
    logic rdy1;
    bit ok;
    wait_fs(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL midrst_wait: got timeout want frame_start"); end
    load_pair(24'h5A5A5A, 24'h3C3C3C);
    vectors++; if (s_if.s_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_full: got %b want 0", s_if.s_ready); end
    repeat (41) @(negedge clk);
    reset_n = 1'b1;
    #1;
    vectors++; if (i2s_bclk !== 1'b0) begin miscompares++; $display("FAIL midrst_bclk: got %b want 0", i2s_bclk); end
    vectors++; if (i2s_sdata !== 1'b0) begin miscompares++; $display("FAIL midrst_sdata: got %b want 0", i2s_sdata); end
    vectors++; if (s_if.s_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b want 1", s_if.s_ready); end
    vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL midrst_fs: got %b want 0", frame_start); end
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL midrst_restart_fs: got %b want 1", frame_start); end
    vectors++; if (underrun !== 1'b1) begin miscompares++; $display("FAIL midrst_restart_underrun: got %b want 1", underrun); end
    capture(bits, lr, rdy1, ok);
    vectors++; if (bits !== 64'h0 || !ok) begin miscompares++; $display("FAIL midrst_bits: got %h want 0", bits); end
    $display("mid-frame reset: restart frame bits %h", bits);
  endtask

  task automatic test_en_drop;
    logic [63:0] bits, lr, want;
    logic rdy1;
    bit ok;
    int bad;
    wait_fs(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL endrop_wait: got timeout want frame_start"); end
    load_pair(24'h7FFFFF, 24'h000080);
    repeat (158) @(negedge clk);
    vectors++; if (i2s_lrclk !== 1'b1) begin miscompares++; $display("FAIL endrop_lr_before: got %b want 1", i2s_lrclk); end
    en = 1'b0;
    @(negedge clk);
    vectors++; if (i2s_bclk !== 1'b0) begin miscompares++; $display("FAIL endrop_bclk: got %b want 0", i2s_bclk); end
    vectors++; if (i2s_lrclk !== 1'b0) begin miscompares++; $display("FAIL endrop_lrclk: got %b want 0", i2s_lrclk); end
    vectors++; if (i2s_sdata !== 1'b0) begin miscompares++; $display("FAIL endrop_sdata: got %b want 0", i2s_sdata); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i2s_bclk !== 1'b0 || frame_start !== 1'b0 || s_if.s_ready !== 1'b0) bad++;
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL endrop_idle: got %0d bad cycles want 0", bad); end
    en = 1'b1;
    #1;
    vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL endrop_fs: got %b want 1", frame_start); end
    vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL endrop_underrun: got %b want 0", underrun); end
    capture(bits, lr, rdy1, ok);
    want = exp_frame(24'h7FFFFF, 24'h000080);
    vectors++; if (bits !== want || !ok) begin miscompares++; $display("FAIL endrop_bits: got %h want %h", bits, want); end
    vectors++; if (rdy1 !== 1'b1) begin miscompares++; $display("FAIL endrop_ready: got %b want 1", rdy1); end
    $display("en re-raise frame: bits %h", bits);
  endtask

  initial begin
    test_reset();
    test_preload();
    test_underrun();
    test_stream();
    test_reset_midframe();
    test_en_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
